// File: rtl/alu_ctrl_decode_if.sv
// Fetch-to-execute bus for the ALU control decode stage.
// The decode stage takes the slave view; the fetch/execute side takes the master view.
interface alu_ctrl_decode_if #(
  parameter int WIDTH_DATA_LENGTH   = 32,
  parameter int WIDTH_ALUSEL_LENGTH = 4,
  parameter int WIDTH_ILLCNT_LENGTH = 8
);
  logic [WIDTH_DATA_LENGTH-1:0]   InstIn;
  logic [WIDTH_DATA_LENGTH-1:0]   PCIn;
  logic                           InValid;
  logic                           InReady;
  logic                           Flush;
  logic                           OutValid;
  logic                           OutReady;
  logic [WIDTH_ALUSEL_LENGTH-1:0] ALUSel;
  logic                           ASel;
  logic                           BSel;
  logic [WIDTH_DATA_LENGTH-1:0]   ImmOut;
  logic [4:0]                     Rs1Addr;
  logic [4:0]                     Rs2Addr;
  logic [4:0]                     RdAddr;
  logic                           RegWEn;
  logic                           IllegalInst;
  logic [WIDTH_DATA_LENGTH-1:0]   PCOut;
  logic [WIDTH_DATA_LENGTH-1:0]   InstOut;
  logic [WIDTH_ILLCNT_LENGTH-1:0] IllegalCount;

  modport master (
    output InstIn, PCIn, InValid, Flush, OutReady,
    input  InReady, OutValid, ALUSel, ASel, BSel, ImmOut, Rs1Addr, Rs2Addr,
           RdAddr, RegWEn, IllegalInst, PCOut, InstOut, IllegalCount
  );

  modport slave (
    input  InstIn, PCIn, InValid, Flush, OutReady,
    output InReady, OutValid, ALUSel, ASel, BSel, ImmOut, Rs1Addr, Rs2Addr,
           RdAddr, RegWEn, IllegalInst, PCOut, InstOut, IllegalCount
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// RV32I decode stage producing the ALU control word, registered behind a
// one-deep valid/ready output buffer with flush and an illegal-instruction counter.
module alu_ctrl_decode #(
  parameter int WIDTH_DATA_LENGTH   = 32,
  parameter int WIDTH_ALUSEL_LENGTH = 4,
  parameter int WIDTH_ILLCNT_LENGTH = 8
) (
  input logic              clk,
  input logic              rst,
  alu_ctrl_decode_if.slave bus
);

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_SLL    = 4'b0010;
  localparam logic [3:0] ALU_SLT    = 4'b0011;
  localparam logic [3:0] ALU_SLTU   = 4'b0100;
  localparam logic [3:0] ALU_XOR    = 4'b0101;
  localparam logic [3:0] ALU_SRL    = 4'b0110;
  localparam logic [3:0] ALU_SRA    = 4'b0111;
  localparam logic [3:0] ALU_OR     = 4'b1000;
  localparam logic [3:0] ALU_AND    = 4'b1001;
  localparam logic [3:0] ALU_PASS_B = 4'b1111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam int DW = WIDTH_DATA_LENGTH;
  localparam int SW = WIDTH_ALUSEL_LENGTH;
  localparam int CW = WIDTH_ILLCNT_LENGTH;

  logic [DW-1:0] inst;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [31:0]   imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  logic [SW-1:0] dec_alu;
  logic          dec_asel;
  logic          dec_bsel;
  logic [31:0]   dec_imm;
  logic          dec_wen;
  logic          dec_ill;

  logic          in_ready;
  logic          load;
  logic          xfer;

  logic          out_valid_d, out_valid_q;
  logic [SW-1:0] alu_sel_d, alu_sel_q;
  logic          a_sel_d, a_sel_q;
  logic          b_sel_d, b_sel_q;
  logic [DW-1:0] imm_d, imm_q;
  logic [4:0]    rs1_d, rs1_q;
  logic [4:0]    rs2_d, rs2_q;
  logic [4:0]    rd_d, rd_q;
  logic          reg_wen_d, reg_wen_q;
  logic          illegal_d, illegal_q;
  logic [DW-1:0] pc_d, pc_q;
  logic [DW-1:0] inst_d, inst_q;
  logic [CW-1:0] ill_cnt_d, ill_cnt_q;

  assign inst   = bus.InstIn;
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  // The ALU shifts by all of DataB, so funct7 must not leak into the shift amount.
  assign imm_sh = {27'b0, inst[24:20]};

  always_comb begin
    dec_alu  = ALU_ADD;
    dec_asel = 1'b0;
    dec_bsel = 1'b0;
    dec_imm  = '0;
    dec_wen  = 1'b0;
    dec_ill  = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_wen = 1'b1;
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000:  dec_alu = ALU_ADD;
            3'b001:  dec_alu = ALU_SLL;
            3'b010:  dec_alu = ALU_SLT;
            3'b011:  dec_alu = ALU_SLTU;
            3'b100:  dec_alu = ALU_XOR;
            3'b101:  dec_alu = ALU_SRL;
            3'b110:  dec_alu = ALU_OR;
            default: dec_alu = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec_alu = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec_alu = ALU_SRA;
        end else begin
          dec_ill = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec_bsel = 1'b1;
        dec_wen  = 1'b1;
        dec_imm  = imm_i;
        case (funct3)
          3'b000: dec_alu = ALU_ADD;
          3'b010: dec_alu = ALU_SLT;
          3'b011: dec_alu = ALU_SLTU;
          3'b100: dec_alu = ALU_XOR;
          3'b110: dec_alu = ALU_OR;
          3'b111: dec_alu = ALU_AND;
          3'b001: begin
            dec_alu = ALU_SLL;
            dec_imm = imm_sh;
            dec_ill = (funct7 != F7_BASE);
          end
          default: begin
            dec_alu = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            dec_imm = imm_sh;
            dec_ill = (funct7 != F7_BASE) && (funct7 != F7_ALT);
          end
        endcase
      end
      OPC_LUI: begin
        dec_alu  = ALU_PASS_B;
        dec_bsel = 1'b1;
        dec_imm  = imm_u;
        dec_wen  = 1'b1;
      end
      OPC_AUIPC: begin
        dec_asel = 1'b1;
        dec_bsel = 1'b1;
        dec_imm  = imm_u;
        dec_wen  = 1'b1;
      end
      OPC_LOAD: begin
        dec_bsel = 1'b1;
        dec_imm  = imm_i;
        dec_wen  = 1'b1;
      end
      OPC_STORE: begin
        dec_bsel = 1'b1;
        dec_imm  = imm_s;
      end
      OPC_BRANCH: begin
        dec_asel = 1'b1;
        dec_bsel = 1'b1;
        dec_imm  = imm_b;
      end
      OPC_JAL: begin
        dec_asel = 1'b1;
        dec_bsel = 1'b1;
        dec_imm  = imm_j;
        dec_wen  = 1'b1;
      end
      OPC_JALR: begin
        dec_bsel = 1'b1;
        dec_imm  = imm_i;
        dec_wen  = 1'b1;
        dec_ill  = (funct3 != 3'b000);
      end
      default: dec_ill = 1'b1;
    endcase

    if (dec_ill) begin
      dec_alu  = ALU_ADD;
      dec_asel = 1'b0;
      dec_bsel = 1'b0;
      dec_imm  = '0;
      dec_wen  = 1'b0;
    end
    if (inst[11:7] == 5'd0) dec_wen = 1'b0;
  end

  assign in_ready = ~out_valid_q | bus.OutReady;
  assign load     = bus.InValid & in_ready & ~bus.Flush;
  assign xfer     = out_valid_q & bus.OutReady;

  always_comb begin
    out_valid_d = out_valid_q;
    alu_sel_d   = alu_sel_q;
    a_sel_d     = a_sel_q;
    b_sel_d     = b_sel_q;
    imm_d       = imm_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    reg_wen_d   = reg_wen_q;
    illegal_d   = illegal_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    ill_cnt_d   = ill_cnt_q;

    if (bus.Flush)  out_valid_d = 1'b0;
    else if (load)  out_valid_d = 1'b1;
    else if (xfer)  out_valid_d = 1'b0;

    if (load) begin
      alu_sel_d = dec_alu;
      a_sel_d   = dec_asel;
      b_sel_d   = dec_bsel;
      imm_d     = dec_imm;
      rs1_d     = inst[19:15];
      rs2_d     = inst[24:20];
      rd_d      = inst[11:7];
      reg_wen_d = dec_wen;
      illegal_d = dec_ill;
      pc_d      = bus.PCIn;
      inst_d    = inst;
    end

    // A flushed instruction never counts as delivered.
    if (xfer && !bus.Flush && illegal_q && !(&ill_cnt_q))
      ill_cnt_d = ill_cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      alu_sel_q   <= ALU_ADD;
      a_sel_q     <= 1'b0;
      b_sel_q     <= 1'b0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      reg_wen_q   <= 1'b0;
      illegal_q   <= 1'b0;
      pc_q        <= '0;
      inst_q      <= '0;
      ill_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_sel_q   <= alu_sel_d;
      a_sel_q     <= a_sel_d;
      b_sel_q     <= b_sel_d;
      imm_q       <= imm_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      reg_wen_q   <= reg_wen_d;
      illegal_q   <= illegal_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      ill_cnt_q   <= ill_cnt_d;
    end
  end

  assign bus.InReady      = in_ready;
  assign bus.OutValid     = out_valid_q;
  assign bus.ALUSel       = alu_sel_q;
  assign bus.ASel         = a_sel_q;
  assign bus.BSel         = b_sel_q;
  assign bus.ImmOut       = imm_q;
  assign bus.Rs1Addr      = rs1_q;
  assign bus.Rs2Addr      = rs2_q;
  assign bus.RdAddr       = rd_q;
  assign bus.RegWEn       = reg_wen_q;
  assign bus.IllegalInst  = illegal_q;
  assign bus.PCOut        = pc_q;
  assign bus.InstOut      = inst_q;
  assign bus.IllegalCount = ill_cnt_q;

endmodule
